// File: rtl/bram_stream_fifo_if.sv
// Stream-in, stream-out and TDP RAM port bundle for bram_stream_fifo.
// The FIFO takes the slave view; the environment (source, sink, RAM) takes the master view.
interface bram_stream_fifo_if #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [DWIDTH-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic [AWIDTH+1:0] count;
    logic              mem_wce;
    logic [AWIDTH-1:0] mem_wa;
    logic [DWIDTH-1:0] mem_wd;
    logic              mem_rce;
    logic [AWIDTH-1:0] mem_ra;
    logic [DWIDTH-1:0] mem_rq;

    modport slave (
        input  s_valid, s_data, m_ready, mem_rq,
        output s_ready, m_valid, m_data, count,
        output mem_wce, mem_wa, mem_wd, mem_rce, mem_ra
    );

    modport master (
        output s_valid, s_data, m_ready, mem_rq,
        input  s_ready, m_valid, m_data, count,
        input  mem_wce, mem_wa, mem_wd, mem_rce, mem_ra
    );
endinterface

// File: rtl/bram_stream_fifo.sv
// First-word-fall-through FIFO controller over an external TDP block RAM
// (port A writes, port B reads); a 2-entry buffer hides the 1-cycle read latency.
module bram_stream_fifo #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    bram_stream_fifo_if.slave   bus
);
    localparam int PW = AWIDTH + 1;
    localparam int CW = AWIDTH + 2;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ;
    logic              inflight_q;
    logic [1:0]        buf_cnt_q, buf_cnt_d, cnt_pop, pend;
    logic [DWIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic              push, pop, issue, full, empty;

    // occ never exceeds 2^AWIDTH, so its top bit alone marks full
    assign occ   = wr_ptr_q - rd_ptr_q;
    assign full  = occ[AWIDTH];
    assign empty = (occ == '0);

    assign bus.s_ready = !rst && !full;
    assign push        = bus.s_valid && bus.s_ready;
    assign bus.m_valid = (buf_cnt_q != 2'd0);
    assign bus.m_data  = buf0_q;
    assign pop         = bus.m_valid && bus.m_ready;

    // Words already committed to the output side: buffered plus the one in flight
    assign pend  = buf_cnt_q + {1'b0, inflight_q};
    assign issue = !rst && !empty && ((pend <= 2'd1) || (pend == 2'd2 && pop));

    assign bus.mem_wce = push;
    assign bus.mem_wa  = wr_ptr_q[AWIDTH-1:0];
    assign bus.mem_wd  = bus.s_data;
    assign bus.mem_rce = issue;
    assign bus.mem_ra  = rd_ptr_q[AWIDTH-1:0];

    assign bus.count = {1'b0, occ} + CW'(inflight_q) + CW'(buf_cnt_q);

    assign wr_ptr_d = wr_ptr_q + PW'(push);
    assign rd_ptr_d = rd_ptr_q + PW'(issue);

    // Shift on pop first, then land returning read data in the first free slot
    always_comb begin
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        cnt_pop = buf_cnt_q - {1'b0, pop};
        if (pop) buf0_d = buf1_q;
        if (inflight_q) begin
            if (cnt_pop == 2'd0) buf0_d = bus.mem_rq;
            else                 buf1_d = bus.mem_rq;
        end
        buf_cnt_d = cnt_pop + {1'b0, inflight_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= issue;
            buf_cnt_q  <= buf_cnt_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
        end
    end
endmodule
